// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared FSM state type and matrix geometry for the MAC memory side
package mac_pkg;

    typedef enum logic [1:0] {IDLE, CLEAR, COMPUTE, DONE} state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam int M       = 4;
    localparam int K       = 4;
    localparam int N       = 4;
    localparam int A_DEPTH = M * K;
    localparam int B_DEPTH = K * N;
    localparam int C_DEPTH = M * N;
    localparam int AW      = $clog2(max3(A_DEPTH, B_DEPTH, C_DEPTH));

endpackage

// File: rtl/mac_sp_ram.sv
// rtl/mac_sp_ram.sv - matrix RAM: sync write, registered read, out-of-range writes dropped / reads give 0
module mac_sp_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    localparam int IW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && (32'(waddr) < DEPTH)) begin
            mem[waddr[IW-1:0]] <= wdata;
        end
    end

    // Read samples the array before this edge's write, so a colliding read sees the old word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= (32'(raddr) < DEPTH) ? mem[raddr[IW-1:0]] : '0;
        end
    end

endmodule

// File: rtl/mac_matrix_mem.sv
// rtl/mac_matrix_mem.sv - A/B/C matrix storage, host port and start/clear/compute/done sequencing
module mac_matrix_mem
    import mac_pkg::*;
#(
    parameter int param_M            = 4,
    parameter int param_K            = 4,
    parameter int param_N            = 4,
    parameter int DATA_WIDTH_INITIAL = 8,
    parameter int DATA_WIDTH_FINAL   = 2 * DATA_WIDTH_INITIAL,
    parameter int TIMEOUT_CYCLES     = 1024,
    parameter int AW = $clog2(max3(param_M * param_K, param_K * param_N, param_M * param_N))
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          host_we,
    input  logic                          host_sel,
    input  logic [AW-1:0]                 host_addr,
    input  logic [DATA_WIDTH_INITIAL-1:0] host_wdata,
    input  logic                          host_start,
    input  logic                          host_rd_en,
    input  logic [AW-1:0]                 host_rd_addr,
    output logic [DATA_WIDTH_FINAL-1:0]   host_rd_data,
    output logic                          host_rd_valid,
    output logic                          busy,
    output logic                          done,
    output logic                          timeout_err,
    output logic                          mac_compute,
    input  logic                          a_b_re,
    input  logic [AW-1:0]                 a_addr,
    input  logic [AW-1:0]                 b_addr,
    output logic [DATA_WIDTH_INITIAL-1:0] a_data,
    output logic [DATA_WIDTH_INITIAL-1:0] b_data,
    input  logic                          c_we,
    input  logic [AW-1:0]                 c_addr,
    input  logic [DATA_WIDTH_FINAL-1:0]   c_data,
    input  logic                          mac_done
);
    localparam int ADEP = param_M * param_K;
    localparam int BDEP = param_K * param_N;
    localparam int CDEP = param_M * param_N;
    localparam int WDW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

    state_t         state, state_nxt;
    logic [AW-1:0]  clr_idx;
    logic [WDW-1:0] wd_cnt;
    logic           clr_last, wd_expired;

    assign clr_last   = (clr_idx == AW'(CDEP - 1));
    assign wd_expired = (wd_cnt == WD_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (host_start) state_nxt = CLEAR;
            CLEAR:   if (clr_last) state_nxt = COMPUTE;
            COMPUTE: if (mac_done || wd_expired) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            clr_idx     <= '0;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
            mac_compute <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            mac_compute <= (state_nxt == COMPUTE);
            busy        <= (state_nxt == COMPUTE) || (state_nxt == DONE);
            done        <= (state_nxt == DONE);
            clr_idx     <= (state == CLEAR) ? clr_idx + 1'b1 : '0;
            if (state != COMPUTE) begin
                wd_cnt <= '0;
            end else if (!wd_expired) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            // A simultaneous mac_done wins over the watchdog and leaves the flag clear.
            if (state == IDLE && host_start) begin
                timeout_err <= 1'b0;
            end else if (state == COMPUTE && wd_expired && !mac_done) begin
                timeout_err <= 1'b1;
            end
        end
    end

    logic in_idle, in_compute, in_clear;
    assign in_idle    = (state == IDLE);
    assign in_compute = (state == COMPUTE);
    assign in_clear   = (state == CLEAR);

    mac_sp_ram #(.DEPTH(ADEP), .WIDTH(DATA_WIDTH_INITIAL), .AW(AW)) u_ram_a (
        .clk   (clk),
        .rstn  (rstn),
        .we    (host_we && !host_sel && in_idle),
        .waddr (host_addr),
        .wdata (host_wdata),
        .re    (a_b_re && in_compute),
        .raddr (a_addr),
        .rdata (a_data)
    );

    mac_sp_ram #(.DEPTH(BDEP), .WIDTH(DATA_WIDTH_INITIAL), .AW(AW)) u_ram_b (
        .clk   (clk),
        .rstn  (rstn),
        .we    (host_we && host_sel && in_idle),
        .waddr (host_addr),
        .wdata (host_wdata),
        .re    (a_b_re && in_compute),
        .raddr (b_addr),
        .rdata (b_data)
    );

    mac_sp_ram #(.DEPTH(CDEP), .WIDTH(DATA_WIDTH_FINAL), .AW(AW)) u_ram_c (
        .clk   (clk),
        .rstn  (rstn),
        .we    (in_clear || (c_we && in_compute)),
        .waddr (in_clear ? clr_idx : c_addr),
        .wdata (in_clear ? '0 : c_data),
        .re    (host_rd_en),
        .raddr (host_rd_addr),
        .rdata (host_rd_data)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            host_rd_valid <= 1'b0;
        end else begin
            host_rd_valid <= host_rd_en;
        end
    end

endmodule

// File: tb/tb_mac_matrix_mem.sv
// tb/tb_mac_matrix_mem.sv - directed self-checking bench for mac_matrix_mem
module tb_mac_matrix_mem;
    localparam int AW = 5;

    logic        clk = 1'b0;
    logic        rstn;
    logic        host_we, host_sel, host_start, host_rd_en;
    logic [AW-1:0] host_addr, host_rd_addr, a_addr, b_addr, c_addr;
    logic [7:0]  host_wdata, a_data, b_data;
    logic [15:0] host_rd_data, c_data;
    logic        host_rd_valid, busy, done, timeout_err, mac_compute;
    logic        a_b_re, c_we, mac_done;

    int checks = 0;
    int errors = 0;
    int n;

    mac_matrix_mem #(.TIMEOUT_CYCLES(16), .AW(AW)) dut (
        .clk(clk), .rstn(rstn),
        .host_we(host_we), .host_sel(host_sel), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_start(host_start), .host_rd_en(host_rd_en), .host_rd_addr(host_rd_addr),
        .host_rd_data(host_rd_data), .host_rd_valid(host_rd_valid),
        .busy(busy), .done(done), .timeout_err(timeout_err), .mac_compute(mac_compute),
        .a_b_re(a_b_re), .a_addr(a_addr), .b_addr(b_addr), .a_data(a_data), .b_data(b_data),
        .c_we(c_we), .c_addr(c_addr), .c_data(c_data), .mac_done(mac_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_compute();
        n = 0;
        while (!mac_compute && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        rstn = 1'b0; host_we = 0; host_sel = 0; host_start = 0; host_rd_en = 0;
        host_addr = '0; host_rd_addr = '0; host_wdata = '0;
        a_b_re = 0; a_addr = '0; b_addr = '0; c_we = 0; c_addr = '0; c_data = '0; mac_done = 0;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_mac_compute", mac_compute, 0);
        check("rst_rd_valid", host_rd_valid, 0);
        check("rst_a_data", a_data, 0);
        rstn = 1'b1;
        tick();

        // A = identity, B[i] = i+1
        host_we = 1;
        for (int i = 0; i < 32; i++) begin
            host_sel   = (i >= 16);
            host_addr  = AW'(i % 16);
            host_wdata = (i < 16) ? (((i / 4) == (i % 4)) ? 8'd1 : 8'd0) : 8'(i - 15);
            tick();
        end
        host_we = 0;

        // Run 1: normal completion, mac_done coincides with the last watchdog cycle
        host_start = 1;
        tick();
        host_start = 0;
        wait_compute();
        check("clear_cycles", n, 16);
        check("busy_in_compute", busy, 1);
        for (int i = 0; i < 16; i++) begin
            c_we = 1; c_addr = AW'(i); c_data = 16'(100 + i);
            a_b_re = (i < 2);
            host_we = (i == 0); host_sel = 0; host_addr = 5'd3; host_wdata = 8'hAA;
            if (i == 0) begin a_addr = 5'd5;  b_addr = 5'd2; end
            if (i == 1) begin a_addr = 5'd17; b_addr = 5'd1; end
            if (i == 2) begin a_addr = 5'd0;  b_addr = 5'd0; end
            mac_done = (i == 15);
            tick();
            if (i == 0) begin
                check("a_rd_5", a_data, 1);
                check("b_rd_2", b_data, 3);
            end
            if (i == 1) begin
                check("a_rd_oor17", a_data, 0);
                check("b_rd_1", b_data, 2);
            end
            if (i == 2) begin
                check("a_hold", a_data, 0);
                check("b_hold", b_data, 2);
            end
        end
        c_we = 0; a_b_re = 0; host_we = 0; mac_done = 0;
        check("done_pulse", done, 1);
        check("busy_in_done", busy, 1);
        check("terr_simul", timeout_err, 0);
        check("mac_compute_off", mac_compute, 0);
        tick();
        check("done_1cycle", done, 0);
        check("busy_fall", busy, 0);

        host_rd_en = 1; host_rd_addr = 5'd7;
        tick();
        check("rd_c7", host_rd_data, 107);
        check("rd_valid", host_rd_valid, 1);
        host_rd_addr = 5'd15;
        tick();
        check("rd_c15", host_rd_data, 115);
        host_rd_addr = 5'd25;
        tick();
        check("rd_oor", host_rd_data, 0);
        check("rd_oor_valid", host_rd_valid, 1);
        host_rd_en = 0;
        a_b_re = 1; a_addr = 5'd0;
        tick();
        a_b_re = 0;
        check("rd_valid_off", host_rd_valid, 0);
        check("a_re_idle_ignored", a_data, 0);

        // Run 2: watchdog timeout
        host_start = 1;
        tick();
        host_start = 0;
        wait_compute();
        check("clear_cycles2", n, 16);
        a_b_re = 1; a_addr = 5'd3; b_addr = 5'd15;
        c_we = 1; c_addr = 5'd20; c_data = 16'h55;
        tick();
        a_b_re = 0; c_we = 0;
        check("a3_not_written_busy", a_data, 0);
        check("b_rd_15", b_data, 16);
        n = 1;
        while (mac_compute && n < 40) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, 16);
        check("timeout_done", done, 1);
        check("timeout_err_set", timeout_err, 1);
        tick();
        check("timeout_err_sticky", timeout_err, 1);
        host_rd_en = 1; host_rd_addr = 5'd4;
        tick();
        host_rd_en = 0;
        check("c_oor_write_dropped", host_rd_data, 0);

        // Run 3: start clears the flag, then reset mid-COMPUTE
        host_start = 1;
        tick();
        host_start = 0;
        check("terr_clear_on_start", timeout_err, 0);
        wait_compute();
        tick();
        check("busy_run3", busy, 1);
        rstn = 1'b0;
        #1;
        check("rst_mid_mac_compute", mac_compute, 0);
        check("rst_mid_busy", busy, 0);
        rstn = 1'b1;
        tick();

        // Run 4: A/B survive the reset
        host_start = 1;
        tick();
        host_start = 0;
        wait_compute();
        check("clear_cycles4", n, 16);
        a_b_re = 1; a_addr = 5'd5; b_addr = 5'd2;
        tick();
        a_b_re = 0;
        check("a_kept_5", a_data, 1);
        check("b_kept_2", b_data, 3);
        mac_done = 1;
        tick();
        mac_done = 0;
        check("done_run4", done, 1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_matrix_mem.md
Name: mac_matrix_mem

Overview:
- Matrix storage and sequencing block that services the pipelined MAC unit from the memory side.
- Holds flattened row-major matrices A (M×K), B (K×N) and C (M×N).
- Answers the MAC unit's A/B read requests with fixed 1-cycle latency, and absorbs its C write-backs.
- Gives a host port for loading A/B, starting a run and reading C back, and runs the start/done handshake with a watchdog.

Parameters:
- param_M, 4, rows of A and C
- param_K, 4, columns of A / rows of B
- param_N, 4, columns of B and C
- DATA_WIDTH_INITIAL, 8, A/B element width
- DATA_WIDTH_FINAL, 2*DATA_WIDTH_INITIAL, C element width
- TIMEOUT_CYCLES, 1024, max cycles in COMPUTE before abort
- AW, $clog2(max(M*K, K*N, M*N)), common address width

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous, active-low reset
- host_we  in  1  host write strobe for A/B
- host_sel  in  1  0 = write A, 1 = write B
- host_addr  in  AW  flattened write index
- host_wdata  in  DATA_WIDTH_INITIAL  write data
- host_start  in  1  start request (level sampled)
- host_rd_en  in  1  C readback request
- host_rd_addr  in  AW  C index
- host_rd_data  out  DATA_WIDTH_FINAL  C readback data
- host_rd_valid  out  1  readback data valid
- busy  out  1  high in COMPUTE and DONE
- done  out  1  1-cycle completion pulse
- timeout_err  out  1  sticky abort flag
- mac_compute  out  1  enable to MAC unit
- a_b_re  in  1  MAC read enable
- a_addr, b_addr  in  AW  MAC read indices
- a_data, b_data  out  DATA_WIDTH_INITIAL  read data
- c_we  in  1  MAC write enable
- c_addr  in  AW  C write index
- c_data  in  DATA_WIDTH_FINAL  C write data
- mac_done  in  1  MAC completion flag

Behaviour:
Reset:
- All outputs are 0 and the FSM is in IDLE.
- Memory contents are not reset, except C, which is cleared on each start.

FSM states: IDLE, CLEAR, COMPUTE, DONE.
- IDLE → CLEAR on host_start. CLEAR writes 0 to one C entry per cycle, for M*N cycles.
- CLEAR → COMPUTE after the last entry. mac_compute is 1 only in COMPUTE, registered, asserting the cycle COMPUTE is entered.
- COMPUTE → DONE when mac_done=1, or when the watchdog reaches TIMEOUT_CYCLES-1. On timeout, set timeout_err.
- DONE → IDLE after exactly 1 cycle. done=1 only in DONE.
- timeout_err clears only on reset or on the next accepted host_start.

Watchdog:
- Counter is zeroed on COMPUTE entry and saturates.

MAC read port:
- If a_b_re=1 in cycle t, a_data/b_data equal A[a_addr]/B[b_addr] in cycle t+1.
- When a_b_re=0, the outputs hold their last value.
- Indices ≥ M*K (A) or ≥ K*N (B) return 0.
- a_b_re is honoured only in COMPUTE; otherwise the data outputs hold.

MAC write port:
- c_we=1 writes C[c_addr]=c_data at the clock edge, only in COMPUTE.
- Indices ≥ M*N are dropped.

Host write port:
- Accepted only in IDLE. Ignored while busy; no error is raised.
- Out-of-range index is dropped.

Host read port:
- host_rd_en in cycle t gives host_rd_data=C[host_rd_addr] and host_rd_valid=1 in cycle t+1.
- Allowed in any state; data is from the C array as of cycle t.
- Out-of-range index returns 0 with valid=1.

Simultaneous events:
- host_start while busy is ignored.
- mac_done and timeout in the same cycle: treat as normal completion, timeout_err stays 0.
- MAC C write and host read to the same index in the same cycle: the read returns the old value.

Reset mid-run:
- Immediate return to IDLE; mac_compute deasserts asynchronously.
- A/B contents are preserved; C contents are undefined.

Decomposition:
- Package mac_pkg holds the FSM state enum (state_t) and the width localparams AW, A_DEPTH, B_DEPTH, C_DEPTH. The MAC unit shares this package.
- One sub-module, mac_sp_ram (parameterised depth/width, sync write, registered read), instantiated for A, B and C.
- C uses a second read port for the host readback, or time-multiplexes it.

Test Plan:
- Load A = I4 (identity, 4×4), B[i] = i+1, pulse host_start → mac_compute rises after 16 CLEAR cycles; a_b_re with a_addr=5, b_addr=2 → a_data=1, b_data=3 next cycle.
- Model MAC writes C[0..15]=100+i then mac_done → done pulse 1 cycle, busy falls; host_rd_addr=7 → host_rd_data=107 one cycle later.
- host_we with host_addr=3, host_wdata=0xAA during COMPUTE → A[3] unchanged after run (readback via MAC port = original value).
- mac_done never asserted, TIMEOUT_CYCLES=16 → FSM leaves COMPUTE on the 16th COMPUTE cycle, timeout_err=1, done pulses; next host_start clears timeout_err.
- c_we with c_addr=20 (out of range) and a_addr=17 → no C change, a_data=0.
- rstn low mid-COMPUTE → mac_compute=0 at once, state IDLE; A/B still hold the preloaded values.
